// File: rtl/datapath_pkg.sv
// Shared types for the multi-cycle datapath: ALU opcodes, ALU FSM states and
// the bus-source priority order of the special registers (after R0..R(NREGS-1)).
package datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Offsets above the general registers; lower index wins the bus.
  localparam int unsigned BS_PC       = 0;
  localparam int unsigned BS_MDR      = 1;
  localparam int unsigned BS_HI       = 2;
  localparam int unsigned BS_LO       = 3;
  localparam int unsigned BS_Y        = 4;
  localparam int unsigned BS_ZLO      = 5;
  localparam int unsigned BS_ZHI      = 6;
  localparam int unsigned BS_NSPECIAL = 7;

endpackage

// File: rtl/mc_datapath_if.sv
// Control/observation bundle of the datapath; master = sequencer, slave = datapath.
interface mc_datapath_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  logic [NREGS-1:0] Rin, Rout;
  logic             PCin, PCout, Yin, Yout, HIin, HIout, LOin, LOout;
  logic             MDRin, MDRout, Read;
  logic [WIDTH-1:0] Mdatain;
  logic             Zlowout, Zhighout;
  logic [3:0]       alu_op;
  logic             alu_start;
  logic             alu_busy, alu_done;
  logic [WIDTH-1:0] bus_out;
  logic             bus_err;

  modport master (
    output Rin, Rout, PCin, PCout, Yin, Yout, HIin, HIout, LOin, LOout,
           MDRin, MDRout, Read, Mdatain, Zlowout, Zhighout, alu_op, alu_start,
    input  alu_busy, alu_done, bus_out, bus_err
  );

  modport slave (
    input  Rin, Rout, PCin, PCout, Yin, Yout, HIin, HIout, LOin, LOout,
           MDRin, MDRout, Read, Mdatain, Zlowout, Zhighout, alu_op, alu_start,
    output alu_busy, alu_done, bus_out, bus_err
  );
endinterface

// File: rtl/mc_alu.sv
// ALU with operand latches, single-cycle ops, Booth multiplier and optional
// restoring divider (enabled by MC_DATAPATH_DIV_EN). Owns the Z register.
module mc_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zlo,
  output logic [WIDTH-1:0] zhi
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_in;
  logic [WIDTH-1:0] zlo_q, zlo_d, zhi_q, zhi_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;   // Booth accumulator / divider remainder
  logic [WIDTH-1:0] qr_q, qr_d;     // multiplier / dividend-quotient shifter
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;       // multiplicand / divisor magnitude

  logic [SHW-1:0]   sh, nsh;
  logic [WIDTH-1:0] res1;
  logic [WIDTH:0]   bsum;

`ifdef MC_DATAPATH_DIV_EN
  logic             dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   rsh, trial;
`endif

  assign op_in = alu_op_e'(op);
  assign busy  = (state_q == ST_ITER);
  assign done  = (state_q == ST_DONE);
  assign zlo   = zlo_q;
  assign zhi   = zhi_q;

  // Rotates use the complementary amount; sh=0 gives a|a = a.
  always_comb begin
    sh  = b_in[SHW-1:0];
    nsh = -sh;
    case (op_in)
      OP_ADD:  res1 = a_in + b_in;
      OP_SUB:  res1 = a_in - b_in;
      OP_AND:  res1 = a_in & b_in;
      OP_OR:   res1 = a_in | b_in;
      OP_SHR:  res1 = a_in >> sh;
      OP_SHRA: res1 = WIDTH'($signed(a_in) >>> sh);
      OP_SHL:  res1 = a_in << sh;
      OP_ROR:  res1 = (a_in >> sh) | (a_in << nsh);
      OP_ROL:  res1 = (a_in << sh) | (a_in >> nsh);
      OP_NEG:  res1 = -b_in;
      OP_NOT:  res1 = ~b_in;
      default: res1 = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    case ({qr_q[0], qm1_q})
      2'b01:   bsum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   bsum = acc_q - {m_q[WIDTH-1], m_q};
      default: bsum = acc_q;
    endcase
`ifdef MC_DATAPATH_DIV_EN
    dz_d   = dz_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    a_d    = a_q;
    rsh    = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    trial  = rsh - {1'b0, m_q};
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          op_d  = op_in;
          cnt_d = '0;
          if (op_in == OP_MUL) begin
            state_d = ST_ITER;
            acc_d   = '0;
            qr_d    = b_in;
            qm1_d   = 1'b0;
            m_d     = a_in;
          end
`ifdef MC_DATAPATH_DIV_EN
          else if (op_in == OP_DIV) begin
            state_d = ST_ITER;
            acc_d   = '0;
            qr_d    = a_in[WIDTH-1] ? -a_in : a_in;
            m_d     = b_in[WIDTH-1] ? -b_in : b_in;
            qneg_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rneg_d  = a_in[WIDTH-1];
            dz_d    = (b_in == '0);
            a_d     = a_in;
          end
`endif
          else begin
            state_d = ST_DONE;
            zlo_d   = res1;
            zhi_d   = '0;
          end
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + SHW'(1);
        if (op_q == OP_MUL) begin
          acc_d = {bsum[WIDTH], bsum[WIDTH:1]};
          qr_d  = {bsum[0], qr_q[WIDTH-1:1]};
          qm1_d = qr_q[0];
          if (cnt_q == LAST) begin
            zhi_d = acc_d[WIDTH-1:0];
            zlo_d = qr_d;
          end
        end
`ifdef MC_DATAPATH_DIV_EN
        else begin
          if (!trial[WIDTH]) begin
            acc_d = trial;
            qr_d  = {qr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rsh;
            qr_d  = {qr_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == LAST) begin
            zlo_d = dz_q ? '1  : (qneg_q ? -qr_d : qr_d);
            zhi_d = dz_q ? a_q : (rneg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0]);
          end
        end
`endif
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      zlo_q   <= '0;
      zhi_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
`ifdef MC_DATAPATH_DIV_EN
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
`ifdef MC_DATAPATH_DIV_EN
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
`endif
    end
  end

endmodule

// File: rtl/mc_datapath.sv
// Register file, special registers and priority bus around mc_alu.
// Divider presence is selected by MC_DATAPATH_DIV_EN inside mc_alu.
module mc_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic         clock,
  input  logic         clear,
  mc_datapath_if.slave dp
);
  localparam int NSRC = NREGS + int'(BS_NSPECIAL);

  logic [NREGS-1:0][WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] pc_q, pc_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d, mdr_q, mdr_d;
  logic [WIDTH-1:0] zlo, zhi, bus;
  logic [NSRC-1:0]             req;
  logic [NSRC-1:0][WIDTH-1:0] src;
  logic                        hit, multi;

  always_comb begin
    req = '0;
    src = '0;
    for (int i = 0; i < NREGS; i++) begin
      req[i] = dp.Rout[i];
      src[i] = r_q[i];
    end
    req[NREGS+BS_PC]  = dp.PCout;    src[NREGS+BS_PC]  = pc_q;
    req[NREGS+BS_MDR] = dp.MDRout;   src[NREGS+BS_MDR] = mdr_q;
    req[NREGS+BS_HI]  = dp.HIout;    src[NREGS+BS_HI]  = hi_q;
    req[NREGS+BS_LO]  = dp.LOout;    src[NREGS+BS_LO]  = lo_q;
    req[NREGS+BS_Y]   = dp.Yout;     src[NREGS+BS_Y]   = y_q;
    req[NREGS+BS_ZLO] = dp.Zlowout;  src[NREGS+BS_ZLO] = zlo;
    req[NREGS+BS_ZHI] = dp.Zhighout; src[NREGS+BS_ZHI] = zhi;
  end

  // First active request wins; any later one flags a conflict.
  always_comb begin
    bus   = '0;
    hit   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i]) begin
        if (!hit) bus = src[i];
        else      multi = 1'b1;
        hit = 1'b1;
      end
    end
  end

  assign dp.bus_out = bus;
  assign dp.bus_err = multi;

  always_comb begin
    for (int i = 0; i < NREGS; i++) r_d[i] = dp.Rin[i] ? bus : r_q[i];
    pc_d  = dp.PCin ? bus : pc_q;
    y_d   = dp.Yin  ? bus : y_q;
    hi_d  = dp.HIin ? bus : hi_q;
    lo_d  = dp.LOin ? bus : lo_q;
    mdr_d = dp.MDRin ? (dp.Read ? dp.Mdatain : bus) : mdr_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_q   <= '0;
      pc_q  <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      mdr_q <= '0;
    end else begin
      r_q   <= r_d;
      pc_q  <= pc_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mdr_q <= mdr_d;
    end
  end

  mc_alu #(.WIDTH(WIDTH)) u_alu (
    .clock (clock),
    .clear (clear),
    .start (dp.alu_start),
    .op    (dp.alu_op),
    .a_in  (y_q),
    .b_in  (bus),
    .busy  (dp.alu_busy),
    .done  (dp.alu_done),
    .zlo   (zlo),
    .zhi   (zhi)
  );

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath (WIDTH=32, NREGS=16); DIV expectations follow MC_DATAPATH_DIV_EN.
module tb_mc_datapath;
  import datapath_pkg::*;
  localparam int W = 32;
  localparam int N = 16;

  logic clock = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mc_datapath_if #(.WIDTH(W), .NREGS(N)) dp ();
  mc_datapath #(.WIDTH(W), .NREGS(N)) dut (.clock(clock), .clear(clear), .dp(dp));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    dp.Rin = '0; dp.Rout = '0;
    dp.PCin = 0; dp.PCout = 0; dp.Yin = 0; dp.Yout = 0;
    dp.HIin = 0; dp.HIout = 0; dp.LOin = 0; dp.LOout = 0;
    dp.MDRin = 0; dp.MDRout = 0; dp.Read = 0; dp.Mdatain = '0;
    dp.Zlowout = 0; dp.Zhighout = 0; dp.alu_op = '0; dp.alu_start = 0;
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    dp.Mdatain = v; dp.Read = 1; dp.MDRin = 1;
    tick();
    dp.Read = 0; dp.MDRin = 0;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    load_mdr(v);
    dp.MDRout = 1; dp.Yin = 1;
    tick();
    dp.MDRout = 0; dp.Yin = 0;
  endtask

  task automatic peek_z(output logic [W-1:0] lo, output logic [W-1:0] hi);
    dp.Zlowout = 1; #1; lo = dp.bus_out; dp.Zlowout = 0;
    dp.Zhighout = 1; #1; hi = dp.bus_out; dp.Zhighout = 0;
    #1;
  endtask

  // B operand comes from MDR; t0 is the cycle in which start is presented.
  task automatic launch(input logic [3:0] op, output int t0);
    dp.MDRout = 1; dp.alu_op = op; dp.alu_start = 1;
    t0 = cyc;
    tick();
    dp.alu_start = 0; dp.MDRout = 0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    int n = 0;
    while (!dp.alu_done && n < 40) begin
      tick();
      n++;
    end
    lat = dp.alu_done ? cyc - t0 : -1;
  endtask

  initial begin
    logic [W-1:0] lo, hi;
    int t0, lat, busy_cnt, done_cnt;
    logic [3:0]   op_t [8];
    logic [W-1:0] exp_t [8];

    idle_all();
    clear = 1;
    tick(); tick();
    clear = 0;

    chk("rst_busy", dp.alu_busy, 0);
    chk("rst_done", dp.alu_done, 0);
    chk("rst_bus", dp.bus_out, 0);
    chk("rst_err", dp.bus_err, 0);
    dp.PCout = 1; #1; chk("rst_pc", dp.bus_out, 0); dp.PCout = 0;
    peek_z(lo, hi);
    chk("rst_zlo", lo, 0);
    chk("rst_zhi", hi, 0);

    // ADD: R1=5, Y=5
    load_mdr(32'd5);
    dp.MDRout = 1; dp.Rin[1] = 1; dp.Yin = 1; #1;
    chk("mdr_bus", dp.bus_out, 32'd5);
    tick();
    dp.MDRout = 0; dp.Rin = '0; dp.Yin = 0;
    dp.Rout[1] = 1; dp.alu_op = OP_ADD; dp.alu_start = 1;
    t0 = cyc;
    tick();
    dp.alu_start = 0; dp.Rout = '0;
    chk("add_done", dp.alu_done, 1);
    chk("add_busy", dp.alu_busy, 0);
    peek_z(lo, hi);
    chk("add_zlo", lo, 32'h0000000A);
    chk("add_zhi", hi, 0);
    tick();
    chk("add_done_drop", dp.alu_done, 0);

    // MUL: -3 * 7
    load_y(32'hFFFFFFFD);
    load_mdr(32'd7);
    launch(OP_MUL, t0);
    peek_z(lo, hi);
    chk("mul_z_hold", lo, 32'h0000000A);
    busy_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      if (dp.alu_busy && !dp.alu_done) busy_cnt++;
      tick();
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_done_t33", dp.alu_done, 1);
    chk("mul_busy_t33", dp.alu_busy, 0);
    peek_z(lo, hi);
    chk("mul_zlo", lo, 32'hFFFFFFEB);
    chk("mul_zhi", hi, 32'hFFFFFFFF);
    tick();

    // DIV: 17 / -5, then 17 / 0
    load_y(32'd17);
    load_mdr(32'hFFFFFFFB);
    launch(OP_DIV, t0);
    wait_done(t0, lat);
`ifdef MC_DATAPATH_DIV_EN
    chk("div_lat", lat, 33);
    peek_z(lo, hi);
    chk("div_zlo", lo, 32'hFFFFFFFD);
    chk("div_zhi", hi, 32'd2);
    tick();
    load_mdr(32'd0);
    launch(OP_DIV, t0);
    wait_done(t0, lat);
    chk("div0_lat", lat, 33);
    peek_z(lo, hi);
    chk("div0_zlo", lo, 32'hFFFFFFFF);
    chk("div0_zhi", hi, 32'd17);
`else
    chk("div_off_lat", lat, 1);
    peek_z(lo, hi);
    chk("div_off_zlo", lo, 0);
    chk("div_off_zhi", hi, 0);
`endif
    tick();

    // MUL 6*7 with a start attempt at T+5 that must be ignored
    load_y(32'd6);
    load_mdr(32'd7);
    launch(OP_MUL, t0);
    while (cyc < t0 + 5) tick();
    dp.alu_op = OP_ADD; dp.MDRout = 1; dp.alu_start = 1;
    tick();
    dp.alu_start = 0; dp.MDRout = 0;
    wait_done(t0, lat);
    chk("mul2_lat", lat, 33);
    peek_z(lo, hi);
    chk("mul2_zlo", lo, 32'd42);
    chk("mul2_zhi", hi, 0);
    tick();

    // clear in cycle T+10 aborts the MUL
    launch(OP_MUL, t0);
    while (cyc < t0 + 10) tick();
    clear = 1;
    tick();
    clear = 0;
    chk("clr_busy", dp.alu_busy, 0);
    chk("clr_done", dp.alu_done, 0);
    peek_z(lo, hi);
    chk("clr_zlo", lo, 0);
    chk("clr_zhi", hi, 0);
    dp.Yout = 1; #1; chk("clr_y", dp.bus_out, 0); dp.Yout = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (dp.alu_done) done_cnt++;
      tick();
    end
    chk("clr_no_done", done_cnt, 0);

    // bus priority and conflict
    load_mdr(32'h11);
    dp.MDRout = 1; dp.Rin[2] = 1; tick(); dp.MDRout = 0; dp.Rin = '0;
    load_mdr(32'h22);
    dp.MDRout = 1; dp.Rin[3] = 1; tick(); dp.MDRout = 0; dp.Rin = '0;
    dp.Rout[2] = 1; dp.Rout[3] = 1; #1;
    chk("bus_r2r3", dp.bus_out, 32'h11);
    chk("err_r2r3", dp.bus_err, 1);
    dp.Rout = '0; #1;
    chk("bus_none", dp.bus_out, 0);
    chk("err_none", dp.bus_err, 0);
    dp.Rout[3] = 1; #1;
    chk("bus_r3", dp.bus_out, 32'h22);
    chk("err_r3", dp.bus_err, 0);
    dp.Rout = '0;
    dp.MDRout = 1; dp.Zlowout = 1; #1;
    chk("bus_mdr_z", dp.bus_out, 32'h22);
    chk("err_mdr_z", dp.bus_err, 1);
    dp.MDRout = 0; dp.Zlowout = 0;
    tick();

    // Y=0x80000001, B=1: MUL then single-cycle ops
    load_y(32'h80000001);
    load_mdr(32'd1);
    launch(OP_MUL, t0);
    wait_done(t0, lat);
    peek_z(lo, hi);
    chk("mul3_zlo", lo, 32'h80000001);
    chk("mul3_zhi", hi, 32'hFFFFFFFF);
    tick();
    op_t  = '{OP_ROR, OP_SHRA, OP_SHR, OP_ROL, OP_SHL, OP_SUB, OP_NEG, 4'd14};
    exp_t = '{32'hC0000000, 32'hC0000000, 32'h40000000, 32'h00000003,
              32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      launch(op_t[i], t0);
      wait_done(t0, lat);
      chk($sformatf("op%0d_lat", op_t[i]), lat, 1);
      peek_z(lo, hi);
      chk($sformatf("op%0d_zlo", op_t[i]), lo, exp_t[i]);
      chk($sformatf("op%0d_zhi", op_t[i]), hi, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter WIDTH, 32, data/bus/register width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter NREGS, 16, general-purpose register count; SHALL be 2 to 32.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 clear  in  1  synchronous, active-high reset.
REQ-005 Rin, Rout  in  NREGS each  per-register bus load enable and bus drive request.
REQ-006 PCin, PCout, Yin, Yout, HIin, HIout, LOin, LOout  in  1 each  special-register load enable and bus drive request.
REQ-007 MDRin, MDRout, Read  in  1 each  MDR load, MDR drive, MDR source select (1 = Mdatain, 0 = bus).
REQ-008 Mdatain  in  WIDTH  memory read data.
REQ-009 Zlowout, Zhighout  in  1 each  Z-half bus drive requests.
REQ-010 alu_op  in  4  operation code.
REQ-011 alu_start  in  1  one-cycle operation launch pulse.
REQ-012 alu_busy, alu_done  out  1 each  ALU busy level and completion pulse.
REQ-013 bus_out  out  WIDTH  current BusMuxOut, for observation.
REQ-014 bus_err  out  1  more than one bus drive request is active this cycle.

Function
REQ-015 Bus: SHALL be combinational; priority R0..R(NREGS-1), PC, MDR, HI, LO, Y, Zlow, Zhigh; no request -> 0; bus_err = 1 when two or more requests are active in the same cycle.
REQ-016 Registers: each SHALL load bus_out when its enable is set; MDR SHALL load Mdatain when Read=1, else bus_out.
REQ-017 Operand capture: alu_start while not busy SHALL latch A=Y, B=bus_out, op=alu_op; alu_start while alu_busy=1 SHALL be ignored.
REQ-018 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(B), 10 NOT(B), 11 MUL, 12 DIV, 13-15 -> result 0; shift amount = B[log2(WIDTH)-1:0].
REQ-019 Single-cycle ops: Zhigh=0, Zlow=result modulo 2^WIDTH; latency 1.
REQ-020 MUL: signed A*B, 2*WIDTH-bit product, Zhigh:Zlow; radix-2 Booth, one bit per cycle; latency WIDTH+1.
REQ-021 DIV: signed A/B truncated toward zero; Zlow=quotient, Zhigh=remainder (sign of dividend); B=0 -> Zlow=all ones, Zhigh=A; latency WIDTH+1 in all cases.
REQ-022 Timing: start sampled at edge T; alu_busy=1 in cycles T+1..T+L-1; Z written at edge T+L; alu_done=1 for exactly cycle T+L; alu_busy=0 in cycle T+L.
REQ-023 FSM: IDLE -> (start, L=1) DONE; IDLE -> (start, MUL/DIV) ITER; ITER -> DONE after WIDTH iterations; DONE -> IDLE; start in DONE SHALL be accepted as from IDLE.
REQ-024 Z SHALL change only at completion or clear; operand changes during ITER SHALL NOT affect the result.

Reset
REQ-025 clear SHALL zero all registers, Z, and iteration counters, force FSM to IDLE, and drive alu_busy=0 and alu_done=0 in the following cycle.
REQ-026 clear has priority over every enable; clear during ITER SHALL abort the operation with no alu_done pulse.

Configuration
REQ-027 Macro MC_DATAPATH_DIV_EN: defined -> DIV per REQ-021; undefined -> no divider logic, op 12 SHALL complete in 1 cycle with Z=0.

Structure
REQ-028 Package datapath_pkg SHALL hold the alu_op enum, FSM state enum, and the bus-source priority constants.
REQ-029 Sub-module mc_alu SHALL contain the operand latches, FSM, single-cycle ops and the iterative MUL/DIV; mc_datapath SHALL contain the registers and the bus.

Verification (WIDTH=32, NREGS=16)
REQ-030 Load R1=5 and Y=5 via Mdatain/MDR; start ADD with R1out -> alu_done at T+1, Zlow=0x0000000A, Zhigh=0.
REQ-031 Y=0xFFFFFFFD, bus=7, MUL -> alu_busy for T+1..T+32, alu_done at T+33, Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFEB.
REQ-032 Y=17, bus=0xFFFFFFFB, DIV -> at T+33, Zlow=0xFFFFFFFD, Zhigh=2; repeat with bus=0 -> Zlow=0xFFFFFFFF, Zhigh=17.
REQ-033 MUL started, clear at T+10 -> alu_busy=0 from T+11, Z=0, no alu_done pulse; a second start at T+5 of a MUL SHALL NOT change the result.
REQ-034 R2=0x11, R3=0x22, R2out and R3out together -> bus_out=0x11, bus_err=1; all out requests low -> bus_out=0, bus_err=0.
REQ-035 Y=0x80000001, bus=1, ROR -> Zlow=0xC0000000; SHRA -> Zlow=0xC0000000; SHR -> Zlow=0x40000000.
